// File: rtl/io_bus_arbiter_if.sv
// Bundle of the two master request/response channels and the shared IO slave
// bus. The arbiter uses the slave modport; whoever plays the masters and the
// IO slave uses the master modport.
interface io_bus_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_byteen;
  logic        m0_ready;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_byteen;
  logic        m1_ready;
  logic        m1_err;

  logic [31:0] rdata;
  logic [31:0] addr_out;
  logic [31:0] wdata_out;
  logic [3:0]  byteen_out;
  logic [31:0] rdata_in;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_byteen,
    input  m1_req, m1_addr, m1_wdata, m1_byteen,
    input  rdata_in,
    output m0_ready, m0_err, m1_ready, m1_err,
    output rdata, addr_out, wdata_out, byteen_out
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_byteen,
    output m1_req, m1_addr, m1_wdata, m1_byteen,
    output rdata_in,
    input  m0_ready, m0_err, m1_ready, m1_err,
    input  rdata, addr_out, wdata_out, byteen_out
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the IO register bus (switches, keys, LED window)
// between the CPU data port (master 0) and the UART loader (master 1).
// Every access walks IDLE -> GRANTx -> RESPx, one cycle per step, so a
// request sampled in IDLE gets its ready pulse two edges later.
//
// state  | meaning
// IDLE   | waiting; latches the winning master's addr/wdata/byteen
// GRANT0 | master 0 access driven on the slave bus (quiet if out of window)
// GRANT1 | master 1 access driven on the slave bus (quiet if out of window)
// RESP0  | m0_ready pulse, m0_err valid
// RESP1  | m1_ready pulse, m1_err valid
module io_bus_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7f50,
  parameter logic [31:0] LIMIT_ADDR = 32'h0000_7f63
) (
  input logic     clk,
  input logic     reset,
  io_bus_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    RESP0  = 3'd3,
    RESP1  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rr_ptr;
  logic        rr_ptr_nxt;
  logic        load;
  logic        load_sel;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_byteen;
  logic        lat_err;
  logic [31:0] rdata_q;
  logic        in_window;
  logic        in_grant;

  // The window check works on the latched address, so a master moving its
  // address after the grant cannot change the access in flight.
  assign in_window = (lat_addr >= BASE_ADDR) && (lat_addr <= LIMIT_ADDR);
  assign in_grant  = (state == GRANT0) || (state == GRANT1);
  assign bus.rdata = rdata_q;

  // State register and round-robin pointer; reset beats every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Arbitration, next state, ready/err pulses and the gated slave bus.
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    load           = 1'b0;
    load_sel       = 1'b0;
    bus.m0_ready   = 1'b0;
    bus.m0_err     = 1'b0;
    bus.m1_ready   = 1'b0;
    bus.m1_err     = 1'b0;
    bus.addr_out   = '0;
    bus.wdata_out  = '0;
    bus.byteen_out = '0;

    unique case (state)
      IDLE: begin
        // rr_ptr names the master that wins a tie.
        if (bus.m0_req && bus.m1_req) begin
          load      = 1'b1;
          load_sel  = rr_ptr;
          state_nxt = rr_ptr ? GRANT1 : GRANT0;
        end else if (bus.m0_req) begin
          load      = 1'b1;
          load_sel  = 1'b0;
          state_nxt = GRANT0;
        end else if (bus.m1_req) begin
          load      = 1'b1;
          load_sel  = 1'b1;
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        state_nxt  = RESP0;
        rr_ptr_nxt = 1'b1;
      end
      GRANT1: begin
        state_nxt  = RESP1;
        rr_ptr_nxt = 1'b0;
      end
      RESP0: begin
        bus.m0_ready = 1'b1;
        bus.m0_err   = lat_err;
        state_nxt    = IDLE;
      end
      RESP1: begin
        bus.m1_ready = 1'b1;
        bus.m1_err   = lat_err;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Out-of-window accesses never reach the slave: the bus stays quiet.
    if (in_grant && in_window) begin
      bus.addr_out   = lat_addr;
      bus.wdata_out  = lat_wdata;
      bus.byteen_out = lat_byteen;
    end
  end

  // Latch the winner's request in IDLE and capture the result at the end of GRANT.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_byteen <= '0;
      lat_err    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (load) begin
        lat_addr   <= load_sel ? bus.m1_addr   : bus.m0_addr;
        lat_wdata  <= load_sel ? bus.m1_wdata  : bus.m0_wdata;
        lat_byteen <= load_sel ? bus.m1_byteen : bus.m0_byteen;
      end
      if (in_grant) begin
        rdata_q <= in_window ? bus.rdata_in : '0;
        lat_err <= !in_window;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: a small IO slave memory, directed scenarios and
// a randomized run checked against a transaction-level model that tracks
// when each access is sampled, granted and answered by edge number.
module tb_io_bus_arbiter;
  localparam logic [31:0] BASE  = 32'h0000_7f50;
  localparam logic [31:0] LIMIT = 32'h0000_7f63;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  io_bus_if bus ();

  io_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= LIMIT);
  endfunction

  function automatic logic [2:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[4:2];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h1111_1111;
      1:       return 32'h2222_2222;
      2:       return 32'h0000_00a5;
      3:       return 32'h4444_4444;
      default: return 32'h5555_5555;
    endcase
  endfunction

  // IO slave: combinational read, byte-enabled write; its own reset wins.
  logic [31:0] slave_mem [0:4];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) slave_mem[i] <= init_val(i);
    end else if (bus.byteen_out != 4'h0 && in_win(bus.addr_out)) begin
      slave_mem[widx(bus.addr_out)] <= merge(slave_mem[widx(bus.addr_out)], bus.wdata_out,
                                             bus.byteen_out);
    end
  end
  assign bus.rdata_in = in_win(bus.addr_out) ? slave_mem[widx(bus.addr_out)] : 32'hdead_beef;

  // Reference model state.
  logic [31:0] ref_mem [0:4];
  int          edge_n = 0;
  int          free_at = 0;
  bit          pref = 1'b0;
  bit          busy = 1'b0;
  int          t_start = 0;
  bit          t_who = 1'b0;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;

  logic        exp_m0_ready, exp_m1_ready, exp_m0_err, exp_m1_err;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] exp_addr_out, exp_wdata_out;
  logic [3:0]  exp_be_out;

  // Advance the model across one rising edge, using the inputs seen at that edge.
  task automatic model_edge();
    exp_m0_ready  = 1'b0;
    exp_m1_ready  = 1'b0;
    exp_m0_err    = 1'b0;
    exp_m1_err    = 1'b0;
    exp_addr_out  = 32'h0;
    exp_wdata_out = 32'h0;
    exp_be_out    = 4'h0;
    if (reset) begin
      busy      = 1'b0;
      free_at   = edge_n + 1;
      pref      = 1'b0;
      exp_rdata = 32'h0;
      for (int i = 0; i < 5; i++) ref_mem[i] = init_val(i);
    end else begin
      if (busy && edge_n == t_start + 1) begin
        if (in_win(t_addr)) begin
          exp_rdata = ref_mem[widx(t_addr)];
          ref_mem[widx(t_addr)] = merge(ref_mem[widx(t_addr)], t_wdata, t_be);
        end else begin
          exp_rdata = 32'h0;
        end
        pref = !t_who;
        if (t_who) begin
          exp_m1_ready = 1'b1;
          exp_m1_err   = !in_win(t_addr);
        end else begin
          exp_m0_ready = 1'b1;
          exp_m0_err   = !in_win(t_addr);
        end
      end
      if (busy && edge_n >= t_start + 2) busy = 1'b0;
      if (!busy && edge_n >= free_at && (bus.m0_req || bus.m1_req)) begin
        t_who   = (bus.m0_req && bus.m1_req) ? pref : bus.m1_req;
        t_addr  = t_who ? bus.m1_addr : bus.m0_addr;
        t_wdata = t_who ? bus.m1_wdata : bus.m0_wdata;
        t_be    = t_who ? bus.m1_byteen : bus.m0_byteen;
        t_start = edge_n;
        busy    = 1'b1;
        free_at = edge_n + 3;
        if (in_win(t_addr)) begin
          exp_addr_out  = t_addr;
          exp_wdata_out = t_wdata;
          exp_be_out    = t_be;
        end
      end
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
    total++;
    if (bus.m0_ready !== 1'b0 || bus.m1_ready !== 1'b0 || bus.m0_err !== 1'b0 || bus.m1_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got r0=%b r1=%b e0=%b e1=%b exp all 0", bus.m0_ready, bus.m1_ready,
               bus.m0_err, bus.m1_err);
    end
    total++;
    if (bus.rdata !== 32'h0 || bus.addr_out !== 32'h0 || bus.wdata_out !== 32'h0 || bus.byteen_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_bus got rdata=%h addr=%h wdata=%h be=%h exp all 0", bus.rdata, bus.addr_out,
               bus.wdata_out, bus.byteen_out);
    end
  endtask

  task automatic test_m0_write();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h7f60; bus.m0_byteen = 4'hf; bus.m0_wdata = 32'h1234_5678;
    tick();
    total++;
    if (bus.byteen_out !== 4'hf || bus.addr_out !== 32'h7f60 || bus.wdata_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL m0w_grant got be=%h addr=%h wdata=%h exp f/00007f60/12345678", bus.byteen_out,
               bus.addr_out, bus.wdata_out);
    end
    bus.m0_addr = 32'h3000; bus.m0_wdata = 32'h0;
    #1;
    total++;
    if (bus.addr_out !== 32'h7f60 || bus.wdata_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL m0w_latched got addr=%h wdata=%h exp 00007f60/12345678", bus.addr_out, bus.wdata_out);
    end
    tick();
    total++;
    if (bus.m0_ready !== 1'b1 || bus.m0_err !== 1'b0 || bus.m1_ready !== 1'b0 || bus.byteen_out !== 4'h0) begin
      bad++;
      $display("FAIL m0w_resp got r0=%b e0=%b r1=%b be=%h exp 1/0/0/0", bus.m0_ready, bus.m0_err,
               bus.m1_ready, bus.byteen_out);
    end
    bus.m0_req = 1'b0;
    tick();
    total++;
    if (bus.m0_ready !== 1'b0 || slave_mem[4] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL m0w_commit got r0=%b mem=%h exp 0/12345678", bus.m0_ready, slave_mem[4]);
    end
  endtask

  task automatic test_m1_read();
    bus.m1_req = 1'b1; bus.m1_addr = 32'h7f58; bus.m1_byteen = 4'h0; bus.m1_wdata = 32'hffff_ffff;
    tick();
    total++;
    if (bus.addr_out !== 32'h7f58 || bus.byteen_out !== 4'h0) begin
      bad++;
      $display("FAIL m1r_grant got addr=%h be=%h exp 00007f58/0", bus.addr_out, bus.byteen_out);
    end
    tick();
    total++;
    if (bus.m1_ready !== 1'b1 || bus.m1_err !== 1'b0 || bus.rdata !== 32'h0000_00a5 || bus.m0_ready !== 1'b0) begin
      bad++;
      $display("FAIL m1r_resp got r1=%b e1=%b rdata=%h r0=%b exp 1/0/000000a5/0", bus.m1_ready,
               bus.m1_err, bus.rdata, bus.m0_ready);
    end
    bus.m1_req = 1'b0;
    tick();
    total++;
    if (bus.byteen_out !== 4'h0 || slave_mem[2] !== 32'h0000_00a5) begin
      bad++;
      $display("FAIL m1r_nowrite got be=%h mem=%h exp 0/000000a5", bus.byteen_out, slave_mem[2]);
    end
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [5];
    bit          errs [5];
    logic [31:0] ea;
    addrs = '{32'h3000, 32'h7f63, 32'h7f64, 32'h7f4f, 32'h7f50};
    errs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      bus.m0_req = 1'b1; bus.m0_addr = addrs[k]; bus.m0_wdata = 32'h5a5a_5a5a;
      bus.m0_byteen = (k == 0) ? 4'hf : 4'h0;
      ea = errs[k] ? 32'h0 : addrs[k];
      tick();
      total++;
      if (bus.addr_out !== ea || bus.byteen_out !== 4'h0) begin
        bad++;
        $display("FAIL oow_grant a=%h got addr=%h be=%h exp %h/0", addrs[k], bus.addr_out,
                 bus.byteen_out, ea);
      end
      tick();
      total++;
      if (bus.m0_ready !== 1'b1 || bus.m0_err !== errs[k]) begin
        bad++;
        $display("FAIL oow_err a=%h got r0=%b e0=%b exp 1/%b", addrs[k], bus.m0_ready, bus.m0_err, errs[k]);
      end
      if (errs[k]) begin
        total++;
        if (bus.rdata !== 32'h0) begin
          bad++;
          $display("FAIL oow_rdata a=%h got %h exp 0", addrs[k], bus.rdata);
        end
      end
      bus.m0_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_contention();
    bit e0, e1;
    apply_reset(1);
    bus.m0_req = 1'b1; bus.m0_addr = 32'h7f50; bus.m0_byteen = 4'h0;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h7f54; bus.m1_byteen = 4'h0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      e0 = (t % 3 == 2) && (((t - 2) / 3) % 2 == 0);
      e1 = (t % 3 == 2) && (((t - 2) / 3) % 2 == 1);
      total++;
      if (bus.m0_ready !== e0 || bus.m1_ready !== e1) begin
        bad++;
        $display("FAIL contention t=%0d got r0=%b r1=%b exp %b/%b", t, bus.m0_ready, bus.m1_ready, e0, e1);
      end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_grant();
    bus.m1_req = 1'b1; bus.m1_addr = 32'h7f54; bus.m1_byteen = 4'h3; bus.m1_wdata = 32'hcafe_babe;
    tick();
    total++;
    if (bus.byteen_out !== 4'h3 || bus.addr_out !== 32'h7f54) begin
      bad++;
      $display("FAIL rst_grant1 got be=%h addr=%h exp 3/00007f54", bus.byteen_out, bus.addr_out);
    end
    reset = 1'b1;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h7f5c; bus.m0_byteen = 4'h0;
    tick();
    total++;
    if (bus.m1_ready !== 1'b0 || bus.m0_ready !== 1'b0 || bus.byteen_out !== 4'h0 ||
        bus.addr_out !== 32'h0 || bus.rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_after got r1=%b r0=%b be=%h addr=%h rdata=%h exp all 0", bus.m1_ready,
               bus.m0_ready, bus.byteen_out, bus.addr_out, bus.rdata);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.addr_out !== 32'h7f5c) begin
      bad++;
      $display("FAIL rst_first_grant got addr=%h exp 00007f5c", bus.addr_out);
    end
    tick();
    total++;
    if (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0 || bus.rdata !== 32'h4444_4444) begin
      bad++;
      $display("FAIL rst_first_resp got r0=%b r1=%b rdata=%h exp 1/0/44444444", bus.m0_ready,
               bus.m1_ready, bus.rdata);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 8))
      0:       return 32'h7f50;
      1:       return 32'h7f54;
      2:       return 32'h7f58;
      3:       return 32'h7f5d;
      4:       return 32'h7f60;
      5:       return 32'h7f63;
      6:       return 32'h7f64;
      7:       return 32'h7f4f;
      default: return $urandom;
    endcase
  endfunction

  task automatic stim(input bit rdy, inout bit act, inout logic [31:0] a, inout logic [31:0] w,
                      inout logic [3:0] be);
    if (rdy) act = 1'b0;
    if (!act && $urandom_range(0, 2) == 0) begin
      act = 1'b1;
      a   = pick_addr();
      w   = $urandom;
      be  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    end else if (act && $urandom_range(0, 15) == 0) begin
      act = 1'b0;
    end else if (act && $urandom_range(0, 3) == 0) begin
      a = pick_addr();
      w = $urandom;
    end
  endtask

  task automatic test_random();
    bit          act0 = 1'b0, act1 = 1'b0;
    logic [31:0] a0 = 32'h0, w0 = 32'h0, a1 = 32'h0, w1 = 32'h0;
    logic [3:0]  b0 = 4'h0, b1 = 4'h0;
    for (int c = 0; c < 400; c++) begin
      stim(exp_m0_ready, act0, a0, w0, b0);
      stim(exp_m1_ready, act1, a1, w1, b1);
      bus.m0_req = act0; bus.m0_addr = a0; bus.m0_wdata = w0; bus.m0_byteen = b0;
      bus.m1_req = act1; bus.m1_addr = a1; bus.m1_wdata = w1; bus.m1_byteen = b1;
      tick();
      total++;
      if (bus.m0_ready !== exp_m0_ready || bus.m1_ready !== exp_m1_ready) begin
        bad++;
        $display("FAIL rnd_ready c=%0d got %b/%b exp %b/%b", c, bus.m0_ready, bus.m1_ready,
                 exp_m0_ready, exp_m1_ready);
      end
      total++;
      if (bus.addr_out !== exp_addr_out || bus.wdata_out !== exp_wdata_out || bus.byteen_out !== exp_be_out) begin
        bad++;
        $display("FAIL rnd_bus c=%0d got %h/%h/%h exp %h/%h/%h", c, bus.addr_out, bus.wdata_out,
                 bus.byteen_out, exp_addr_out, exp_wdata_out, exp_be_out);
      end
      total++;
      if (bus.m0_ready && bus.m1_ready) begin
        bad++;
        $display("FAIL rnd_both_ready c=%0d got 1/1 exp at most one", c);
      end
      if (exp_m0_ready || exp_m1_ready) begin
        total++;
        if (bus.rdata !== exp_rdata || (exp_m0_ready && bus.m0_err !== exp_m0_err) ||
            (exp_m1_ready && bus.m1_err !== exp_m1_err)) begin
          bad++;
          $display("FAIL rnd_resp c=%0d got rdata=%h e0=%b e1=%b exp %h/%b/%b", c, bus.rdata,
                   bus.m0_err, bus.m1_err, exp_rdata, exp_m0_err, exp_m1_err);
        end
      end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    bus.m0_req = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0; bus.m0_byteen = 4'h0;
    bus.m1_req = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0; bus.m1_byteen = 4'h0;
    test_reset();
    test_m0_write();
    test_m1_read();
    test_out_of_window();
    test_contention();
    test_reset_in_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO register bus (DIP switches, user keys, LED window at 0x7f50–0x7f63) between two masters.
- Master 0 is the CPU data port; master 1 is the UART debug/loader master.
- Each access runs a fixed request/grant/response sequence with round-robin arbitration and an address-window check.
- Sits between the masters and the IO slave; the slave's read path is combinational on `addr_out`.

Parameters:
- BASE_ADDR, 32'h0000_7f50, lowest word address of the IO window (inclusive)
- LIMIT_ADDR, 32'h0000_7f63, highest byte address of the IO window (inclusive)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- m0_req  input  1  master 0 request; held high until m0_ready
- m0_addr  input  32  master 0 byte address
- m0_wdata  input  32  master 0 write data
- m0_byteen  input  4  master 0 byte enables; 4'b0000 = read
- m0_ready  output  1  one-cycle completion pulse to master 0
- m0_err  output  1  qualified by m0_ready; address outside window
- m1_req, m1_addr, m1_wdata, m1_byteen, m1_ready, m1_err  same as master 0, for master 1
- rdata  output  32  registered read data, shared; valid while either ready is high
- addr_out  output  32  slave address
- wdata_out  output  32  slave write data
- byteen_out  output  4  slave byte enables (write strobe)
- rdata_in  input  32  slave read data, combinational on addr_out

Behaviour:
- **Reset (synchronous)**
  - state = IDLE; rr_ptr = 0, so master 0 wins the first tie.
  - m0_ready, m1_ready, m0_err, m1_err = 0.
  - rdata = 0; addr_out, wdata_out, byteen_out = 0.
- **FSM states:** IDLE, GRANT0, GRANT1, RESP0, RESP1.
- **IDLE**
  - No request: stay in IDLE.
  - Only m0_req: go to GRANT0. Only m1_req: go to GRANT1.
  - Both requests: grant the master not equal to rr_ptr's last winner. rr_ptr=0 gives master 0, rr_ptr=1 gives master 1.
  - Latch the granted master's addr, wdata and byteen into internal registers on this edge.
- **GRANTx (exactly one cycle)**
  - In-window check: BASE_ADDR <= addr <= LIMIT_ADDR.
  - In-window: addr_out = latched addr and wdata_out = latched wdata. byteen_out = latched byteen, high only during this cycle. The slave write commits on the closing edge. rdata <= rdata_in on the closing edge.
  - Out-of-window: byteen_out = 0, addr_out = 0, wdata_out = 0. rdata <= 0 and the err flag is set for the response.
  - On exit, rr_ptr flips to point past x: after serving 0, rr_ptr=1; after serving 1, rr_ptr=0.
- **RESPx (exactly one cycle)**
  - mx_ready = 1, and mx_err is valid. The other master's ready stays 0.
  - Next state is IDLE.
  - A master still holding req in this cycle is not re-granted until IDLE samples it again.
- **Latency and throughput**
  - Latency from req sampled in IDLE to ready is 3 cycles (IDLE→GRANT→RESP).
  - Throughput is one access per 3 cycles.
- **Bus quiet rule:** outside GRANTx, addr_out, wdata_out and byteen_out are all 0.
- **Request dropped mid-transaction** (protocol violation): the transaction still completes and ready still pulses; no abort.
- **Latched inputs:** a master changing addr/data after grant has no effect on the current access.
- **Byte enables:** passed through unchanged; no alignment correction. addr_out carries the full byte address.
- **Reset mid-operation:** reset wins over every transition. A write whose GRANT cycle coincides with reset still has byteen_out driven for that cycle, but the slave's own reset takes priority.
- **Simultaneous arrival:** both masters requesting every IDLE are served alternately, 0,1,0,1…, starting with 0 after reset.

Test Plan:
1. **Master 0 write.** After reset, m0_req=1, m0_addr=0x7f60, m0_byteen=4'hf, m0_wdata=0x12345678.
   - Cycle 2 after req: byteen_out=4'hf, addr_out=0x7f60, wdata_out=0x12345678.
   - Cycle 3: m0_ready=1, m0_err=0.
2. **Master 1 read.** m1_req=1, m1_addr=0x7f58, byteen=0, slave rdata_in=0x000000A5 while addr_out=0x7f58.
   - m1_ready=1 with rdata=0x000000A5.
   - byteen_out stays 0 throughout.
3. **Contention.** Both req held high continuously from reset.
   - Grants in order m0, m1, m0, m1; each ready arrives 3 cycles apart.
   - m0_ready and m1_ready are never high together.
4. **Out-of-window access.** m0_addr=0x0000_3000, byteen=4'hf.
   - byteen_out=0 and addr_out=0 in every cycle.
   - m0_ready=1, m0_err=1, rdata=0.
   - Boundary checks: 0x7f63 gives err=0; 0x7f64 gives err=1.
5. **Reset during GRANT1.** Assert reset during the GRANT1 cycle.
   - Next cycle: state IDLE, m1_ready=0, outputs 0, rr_ptr=0.
   - Then with both requests high, master 0 is granted first.
